// File: rtl/oisc_fetch_if.sv
// -----------------------------------------------------------------------------
// oisc_fetch_if
// Bundle of every non-clock/non-reset signal of the OISC instruction fetch
// stage: core control (Start, Reset, BootAddr, Redirect, RedirectPC), the
// instruction-memory request/response channel and the InstructionRead
// valid/ready channel towards the move core.
//   modport master : the fetch stage itself
//   modport slave  : the environment (core + instruction memory)
// Optional feature macro: OISC_FETCH_PC_TAG_EN adds InstructionReadPC.
// -----------------------------------------------------------------------------
interface oisc_fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               Start;
    logic               Reset;
    logic [ADDR_W-1:0]  BootAddr;
    logic               Redirect;
    logic [ADDR_W-1:0]  RedirectPC;
    logic               MemReqValid;
    logic               MemReqReady;
    logic [ADDR_W-1:0]  MemReqAddr;
    logic               MemRspValid;
    logic [INSTR_W-1:0] MemRspData;
    logic               InstructionReadValid;
    logic               InstructionReadReady;
    logic [INSTR_W-1:0] InstructionReadData;
`ifdef OISC_FETCH_PC_TAG_EN
    logic [ADDR_W-1:0]  InstructionReadPC;
`endif
    logic               Busy;

    modport master (
        input  Start, Reset, BootAddr, Redirect, RedirectPC,
               MemReqReady, MemRspValid, MemRspData, InstructionReadReady,
        output MemReqValid, MemReqAddr, InstructionReadValid, InstructionReadData,
`ifdef OISC_FETCH_PC_TAG_EN
               InstructionReadPC,
`endif
               Busy
    );

    modport slave (
        output Start, Reset, BootAddr, Redirect, RedirectPC,
               MemReqReady, MemRspValid, MemRspData, InstructionReadReady,
        input  MemReqValid, MemReqAddr, InstructionReadValid, InstructionReadData,
`ifdef OISC_FETCH_PC_TAG_EN
               InstructionReadPC,
`endif
               Busy
    );
endinterface

// File: rtl/oisc_fetch.sv
// -----------------------------------------------------------------------------
// oisc_fetch
// Instruction fetch stage in front of the OISC move core. Issues sequential
// word-address requests, buffers in-order responses in a DEPTH-entry prefetch
// FIFO and hands them to the core over InstructionRead. A Redirect (PC write)
// or soft Reset drops every word still in flight and restarts cleanly.
// Ports:
//   CLK  - rising-edge clock
//   RST  - asynchronous active-low reset
//   bus  - oisc_fetch_if.master (control, memory request/response, core side)
// Optional feature macro: OISC_FETCH_PC_TAG_EN -- FIFO entries also carry the
// request address, exposed as InstructionReadPC.
// -----------------------------------------------------------------------------
module oisc_fetch #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    oisc_fetch_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);   // outstanding / discard / count
    localparam int PW = $clog2(DEPTH);       // FIFO and tag-queue pointers
`ifdef OISC_FETCH_PC_TAG_EN
    localparam int EW = ADDR_W + INSTR_W;    // {PC, INSTR}
`else
    localparam int EW = INSTR_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     out_q,      out_d;
    logic [CW-1:0]     discard_q,  discard_d;
    logic [CW-1:0]     count_q,    count_d;
    logic [PW-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [EW-1:0]     fifo_q [DEPTH];
    logic [EW-1:0]     fifo_d [DEPTH];
`ifdef OISC_FETCH_PC_TAG_EN
    logic [ADDR_W-1:0] tag_q [DEPTH];
    logic [ADDR_W-1:0] tag_d [DEPTH];
    logic [PW-1:0]     tag_wr_q, tag_wr_d;
    logic [PW-1:0]     tag_rd_q, tag_rd_d;
`endif

    logic              run_s, req_valid_s, req_fire_s, rd_valid_s, pop_s;
    logic              rsp_s, push_s;
    logic [CW:0]       credit_s;
    logic [CW-1:0]     out_post_s, disc_post_s;
    logic [EW-1:0]     entry_s;

    // Handshake qualification; Redirect/Reset withdraw both valids in the same cycle.
    always_comb begin
        run_s       = (state_q == ST_RUN);
        credit_s    = {1'b0, out_q} + {1'b0, count_q};
        req_valid_s = run_s & ~bus.Redirect & ~bus.Reset & (credit_s < (CW+1)'(DEPTH));
        req_fire_s  = req_valid_s & bus.MemReqReady;
        rd_valid_s  = (count_q != '0) & run_s & ~bus.Redirect & ~bus.Reset;
        pop_s       = rd_valid_s & bus.InstructionReadReady;
        rsp_s       = bus.MemRspValid;
        // A response is kept only when nothing is pending discard and the
        // path is not being abandoned this very cycle.
        push_s      = rsp_s & (discard_q == '0) & run_s & ~bus.Redirect & ~bus.Reset;
        out_post_s  = out_q + CW'(req_fire_s) - CW'(rsp_s);
        disc_post_s = (rsp_s && (discard_q != '0)) ? (discard_q - CW'(1'b1)) : discard_q;
`ifdef OISC_FETCH_PC_TAG_EN
        entry_s     = {tag_q[tag_rd_q], bus.MemRspData};
`else
        entry_s     = bus.MemRspData;
`endif
    end

    // Next-state for FSM, counters and pointers.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = req_fire_s ? (fetch_pc_q + ADDR_W'(1'b1)) : fetch_pc_q;
        out_d      = out_post_s;
        discard_d  = disc_post_s;
        count_d    = count_q + CW'(push_s) - CW'(pop_s);
        wr_ptr_d   = wr_ptr_q + PW'(push_s);
        rd_ptr_d   = rd_ptr_q + PW'(pop_s);
        if (bus.Reset) begin
            // Everything still in flight becomes wrong-path.
            state_d   = ST_IDLE;
            discard_d = out_post_s;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.Start) begin
                        fetch_pc_d = bus.BootAddr;
                        state_d    = (disc_post_s == '0) ? ST_RUN : ST_FLUSH;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.Redirect) begin
                        // No request can fire here, so out_post_s already
                        // excludes a response landing in this cycle.
                        fetch_pc_d = bus.RedirectPC;
                        discard_d  = out_post_s;
                        count_d    = '0;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        state_d    = (out_post_s == '0) ? ST_RUN : ST_FLUSH;
                    end else begin
                        state_d    = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (disc_post_s == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FIFO storage and request-address tag queue write data.
    always_comb begin
        fifo_d = fifo_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = entry_s;
        end else begin
            fifo_d[wr_ptr_q] = fifo_q[wr_ptr_q];
        end
`ifdef OISC_FETCH_PC_TAG_EN
        // Tags follow every accepted request, independent of flushes, so the
        // read side stays aligned with the in-order response stream.
        tag_d    = tag_q;
        tag_wr_d = tag_wr_q + PW'(req_fire_s);
        tag_rd_d = tag_rd_q + PW'(rsp_s);
        if (req_fire_s) begin
            tag_d[tag_wr_q] = fetch_pc_q;
        end else begin
            tag_d[tag_wr_q] = tag_q[tag_wr_q];
        end
`endif
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= '0;
            out_q      <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
`ifdef OISC_FETCH_PC_TAG_EN
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_q     <= fifo_d;
`ifdef OISC_FETCH_PC_TAG_EN
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_q      <= tag_d;
`endif
        end
    end

    assign bus.MemReqValid          = req_valid_s;
    assign bus.MemReqAddr           = fetch_pc_q;
    assign bus.InstructionReadValid = rd_valid_s;
    assign bus.InstructionReadData  = fifo_q[rd_ptr_q][INSTR_W-1:0];
`ifdef OISC_FETCH_PC_TAG_EN
    assign bus.InstructionReadPC    = fifo_q[rd_ptr_q][EW-1:INSTR_W];
`endif
    assign bus.Busy                 = (state_q != ST_IDLE) | (out_q != '0);

endmodule

// File: tb/tb_oisc_fetch.sv
// -----------------------------------------------------------------------------
// tb_oisc_fetch
// Directed scenarios followed by a randomized phase. The instruction memory is
// an in-order queue of accepted requests; every delivered word is compared to
// the next address of the current fetch path (restarted at each Start or
// Redirect), so any wrong-path, lost or duplicated word shows up.
// -----------------------------------------------------------------------------
module tb_oisc_fetch;
    localparam int AW    = 16;
    localparam int IW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    oisc_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();
    oisc_fetch #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            epoch;
    } req_t;

    req_t          memq[$];
    int            errors = 0;
    int            checks = 0;
    int            epoch = 0;
    int            rsp_epoch = 0;
    int            rsp_pct = 100;
    int            pops = 0;
    bit            running = 1'b0;
    logic [AW-1:0] exp_req = '0;
    logic [AW-1:0] exp_del = '0;
    logic          o_fire, o_pop, o_rv, o_iv;
    logic [AW-1:0] o_addr;
    logic [IW-1:0] o_data;

    function automatic logic [IW-1:0] mdata(input logic [AW-1:0] a);
        return a ^ 16'h3C5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present the next in-order memory response (or none) for the coming cycle.
    task automatic prep_rsp();
        req_t e;
        if (memq.size() != 0 && int'($urandom_range(0, 99)) < rsp_pct) begin
            e = memq.pop_front();
            bus.MemRspValid = 1'b1;
            bus.MemRspData  = mdata(e.addr);
            rsp_epoch       = e.epoch;
        end else begin
            bus.MemRspValid = 1'b0;
            bus.MemRspData  = 16'h0000;
        end
    endtask

    function automatic bit stale_pending();
        foreach (memq[i]) begin
            if (memq[i].epoch != epoch) return 1'b1;
        end
        return (bus.MemRspValid === 1'b1) && (rsp_epoch != epoch);
    endfunction

    // One clock: observe outputs, check against the path model, advance memory.
    task automatic cycle();
        int fe;
        #1;
        o_rv   = bus.MemReqValid;
        o_iv   = bus.InstructionReadValid;
        o_fire = o_rv & bus.MemReqReady;
        o_addr = bus.MemReqAddr;
        o_pop  = o_iv & bus.InstructionReadReady;
        o_data = bus.InstructionReadData;
        if (bus.Reset || bus.Redirect || !running) begin
            chk("gate_req", 32'(o_rv), 32'd0);
            chk("gate_ird", 32'(o_iv), 32'd0);
        end
        if (o_fire) begin
            chk("req_addr", 32'(o_addr), 32'(exp_req));
            exp_req = exp_req + 16'd1;
        end
        if (o_pop) begin
            chk("ird_data", 32'(o_data), 32'(mdata(exp_del)));
`ifdef OISC_FETCH_PC_TAG_EN
            chk("ird_pc", 32'(bus.InstructionReadPC), 32'(exp_del));
`endif
            exp_del = exp_del + 16'd1;
            pops++;
        end
        fe = epoch;
        if (bus.Reset) begin
            running = 1'b0;
            epoch++;
        end else if (bus.Start && !running) begin
            running = 1'b1;
            exp_req = bus.BootAddr;
            exp_del = bus.BootAddr;
            epoch++;
        end else if (bus.Redirect && running) begin
            exp_req = bus.RedirectPC;
            exp_del = bus.RedirectPC;
            epoch++;
        end
        @(posedge clk);
        if (o_fire) begin
            memq.push_back('{o_addr, fe});
            chk("credit", 32'(memq.size() <= DEPTH), 32'd1);
        end
        @(negedge clk);
        prep_rsp();
    endtask

    task automatic soft_reset_drain();
        bus.Reset = 1'b1;
        cycle();
        bus.Reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (memq.size() == 0 && bus.MemRspValid !== 1'b1) break;
            cycle();
        end
        chk("drain_busy", 32'(bus.Busy), 32'd0);
    endtask

    task automatic issue_n(input int n);
        int f = 0;
        for (int i = 0; i < 20 && f < n; i++) begin
            cycle();
            if (o_fire) f++;
        end
        chk("issue_count", 32'(f), 32'(n));
    endtask

    task automatic wait_pop(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (o_pop) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            n, f, p0, r;
        logic [AW-1:0] addrs[$];

        rst_n = 1'b0;
        bus.Start = 1'b0;  bus.Reset = 1'b0;  bus.BootAddr = 16'h0000;
        bus.Redirect = 1'b0;  bus.RedirectPC = 16'h0000;
        bus.MemReqReady = 1'b1;  bus.MemRspValid = 1'b0;  bus.MemRspData = 16'h0000;
        bus.InstructionReadReady = 1'b1;

        // Reset values
        #2;
        chk("rst_reqv", 32'(bus.MemReqValid), 32'd0);
        chk("rst_addr", 32'(bus.MemReqAddr), 32'd0);
        chk("rst_irdv", 32'(bus.InstructionReadValid), 32'd0);
        chk("rst_data", 32'(bus.InstructionReadData), 32'd0);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        cycle();

        // 1: boot at 0x10, 1-cycle memory, core always ready
        bus.BootAddr = 16'h0010;
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n++;
            if (o_pop) break;
        end
        chk("fill_latency", 32'(n), 32'd3);
        chk("first_word", 32'(o_data), 32'(mdata(16'h0010)));
        p0 = pops;
        repeat (8) cycle();
        chk("throughput", 32'(pops - p0), 32'd8);

        // 2: core stalled -> credits cap requests at DEPTH
        soft_reset_drain();
        bus.InstructionReadReady = 1'b0;
        bus.BootAddr = 16'h0100;
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        f = 0;
        repeat (15) begin cycle(); if (o_fire) f++; end
        chk("stall_reqs", 32'(f), 32'd4);
        chk("stall_valid", 32'(o_rv), 32'd0);
        bus.InstructionReadReady = 1'b1;
        cycle();
        bus.InstructionReadReady = 1'b0;
        f = 0;
        repeat (10) begin cycle(); if (o_fire) f++; end
        chk("one_slot_req", 32'(f), 32'd1);

        // 3: Redirect with 3 requests outstanding
        bus.InstructionReadReady = 1'b1;
        soft_reset_drain();
        rsp_pct = 0;
        bus.BootAddr = 16'h0300;
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        issue_n(3);
        bus.MemReqReady = 1'b0;
        bus.Redirect = 1'b1;
        bus.RedirectPC = 16'h0200;
        cycle();
        bus.Redirect = 1'b0;
        bus.MemReqReady = 1'b1;
        rsp_pct = 100;
        repeat (3) begin
            cycle();
            chk("flush_req", 32'(o_rv), 32'd0);
            chk("flush_ird", 32'(o_iv), 32'd0);
        end
        wait_pop("redir_pop");
        chk("redir_first", 32'(o_data), 32'(mdata(16'h0200)));

        // 4: address wrap
        soft_reset_drain();
        bus.BootAddr = 16'hFFFE;
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        addrs.delete();
        for (int i = 0; i < 20 && addrs.size() < 4; i++) begin
            cycle();
            if (o_fire) addrs.push_back(o_addr);
        end
        chk("wrap_cnt", 32'(addrs.size()), 32'd4);
        if (addrs.size() == 4) begin
            chk("wrap_a0", 32'(addrs[0]), 32'h0000FFFE);
            chk("wrap_a1", 32'(addrs[1]), 32'h0000FFFF);
            chk("wrap_a2", 32'(addrs[2]), 32'h00000000);
            chk("wrap_a3", 32'(addrs[3]), 32'h00000001);
        end

        // 5: soft Reset with 2 outstanding, Start next cycle
        soft_reset_drain();
        rsp_pct = 0;
        bus.BootAddr = 16'h0500;
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        issue_n(2);
        bus.MemReqReady = 1'b0;
        bus.Reset = 1'b1;
        cycle();
        bus.Reset = 1'b0;
        chk("busy_outst", 32'(bus.Busy), 32'd1);
        bus.MemReqReady = 1'b1;
        rsp_pct = 100;
        bus.BootAddr = 16'h0040;
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        wait_pop("sreset_pop");
        chk("sreset_first", 32'(o_data), 32'(mdata(16'h0040)));

        // 6: request held under memory backpressure, then async reset
        soft_reset_drain();
        bus.MemReqReady = 1'b0;
        bus.BootAddr = 16'h0600;
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        repeat (5) begin
            cycle();
            chk("hold_valid", 32'(o_rv), 32'd1);
            chk("hold_addr", 32'(o_addr), 32'h00000600);
        end
        bus.MemReqReady = 1'b1;
        repeat (6) cycle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_reqv", 32'(bus.MemReqValid), 32'd0);
        chk("arst_addr", 32'(bus.MemReqAddr), 32'd0);
        chk("arst_irdv", 32'(bus.InstructionReadValid), 32'd0);
        chk("arst_data", 32'(bus.InstructionReadData), 32'd0);
        chk("arst_busy", 32'(bus.Busy), 32'd0);
`ifdef OISC_FETCH_PC_TAG_EN
        chk("arst_pc", 32'(bus.InstructionReadPC), 32'd0);
`endif
        memq.delete();
        running = 1'b0;
        epoch++;
        bus.MemRspValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized phase
        rsp_pct = 70;
        p0 = pops;
        for (int k = 0; k < 1500; k++) begin
            bus.MemReqReady          = ($urandom_range(0, 3) != 0);
            bus.InstructionReadReady = ($urandom_range(0, 3) != 0);
            bus.Start    = 1'b0;
            bus.Reset    = 1'b0;
            bus.Redirect = 1'b0;
            r = int'($urandom_range(0, 99));
            if (!running) begin
                if (r < 25) begin
                    bus.Start    = 1'b1;
                    bus.BootAddr = exp_req + 16'h1000 + 16'($urandom_range(0, 16'h2000));
                end
            end else if (r < 2) begin
                bus.Reset = 1'b1;
            end else if (r < 6 && !stale_pending()) begin
                bus.Redirect   = 1'b1;
                bus.RedirectPC = exp_req + 16'h1000 + 16'($urandom_range(0, 16'h2000));
            end
            cycle();
        end
        bus.Start = 1'b0;  bus.Reset = 1'b0;  bus.Redirect = 1'b0;
        chk("rand_progress", 32'(pops - p0 > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
